sync_wr_rd_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 28 ++
 rtl/sync_wr_rd_fifo.sv | 71 +++++++
 tb/tb_sync_wr_rd_fifo.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, status type and clog2 helper for the sync FIFO
package fifo_pkg;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
    localparam int FIFO_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int FIFO_CW_DEF = clog2(FIFO_DEPTH_DEF) + 1;
    typedef struct packed {
        logic                   full;
        logic                   empty;
        logic [FIFO_CW_DEF-1:0] count;
    } fifo_status_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array, one write port, one registered read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    // storage array is deliberately not reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // read register clears on reset and holds when no read is accepted
    always_ff @(posedge clk) begin
        if (!rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_wr_rd_fifo.sv
// sync_wr_rd_fifo: single-clock FIFO with occupancy/flags; FIFO_ERR_EN adds sticky overflow/underflow and assertions
module sync_wr_rd_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
`ifdef FIFO_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);
    logic [AW-1:0] wptr, rptr;
    logic wr_acc, rd_acc;
    // accepts are gated by rst so strobes (even X) are ignored during reset
    assign rd_acc = rst && rd && !empty;
    assign wr_acc = rst && wr && (!full || rd_acc);
    assign full   = count == (AW+1)'(DEPTH);
    assign empty  = count == '0;
    // pointers, occupancy and read-valid pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            dout_vld <= 1'b0;
        end else begin
            wptr     <= wptr + AW'(wr_acc);
            rptr     <= rptr + AW'(rd_acc);
            count    <= count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
            dout_vld <= rd_acc;
        end
    end
    fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rptr),
        .rdata (dout)
    );
`ifdef FIFO_ERR_EN
    // sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr && !wr_acc) overflow <= 1'b1;
            if (rd && empty) underflow <= 1'b1;
        end
    end
    a_no_wr_full: assert property (@(posedge clk) disable iff (!rst) (wr_acc && full) |-> rd_acc);
    a_vld_past:   assert property (@(posedge clk) disable iff (!rst) dout_vld |-> $past(rd_acc));
    a_flags:      assert property (@(posedge clk) disable iff (!rst) !(full && empty));
`endif
endmodule

// File: tb/tb_sync_wr_rd_fifo.sv
// tb_sync_wr_rd_fifo: directed stimulus with a read-data scoreboard for sync_wr_rd_fifo
module tb_sync_wr_rd_fifo;
    localparam int W = 8;
    localparam int D = 8;
    logic clk = 1'b0;
    logic rst, wr, rd;
    logic [W-1:0] din, dout;
    logic dout_vld, full, empty;
    logic [3:0] count;
`ifdef FIFO_ERR_EN
    logic overflow, underflow;
`endif
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] m [$];
    logic [W-1:0] exp_q [$];
    logic ov_m = 1'b0;
    logic un_m = 1'b0;
    sync_wr_rd_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .din      (din),
        .rd       (rd),
        .dout     (dout),
        .dout_vld (dout_vld),
        .full     (full),
        .empty    (empty),
        .count    (count)
`ifdef FIFO_ERR_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask
    // monitor: every dout_vld pulse must match the oldest expected word
    always @(negedge clk) begin
        if (dout_vld === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL dout_unexpected: got %0h with no read outstanding at %0t", dout, $time);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_err++;
                    $display("FAIL dout: got %0h expected %0h at %0t", dout, e, $time);
                end
            end
        end
    end
    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(m.size()));
        chk({tag, "_full"}, 32'(full), 32'(m.size() == D));
        chk({tag, "_empty"}, 32'(empty), 32'(m.size() == 0));
`ifdef FIFO_ERR_EN
        chk({tag, "_overflow"}, 32'(overflow), 32'(ov_m));
        chk({tag, "_underflow"}, 32'(underflow), 32'(un_m));
`endif
    endtask
    task automatic step(input logic w, input logic r, input logic [W-1:0] d, input string tag);
        bit ra, wa;
        wr = w;
        rd = r;
        din = d;
        ra = r && m.size() != 0;
        wa = w && (m.size() != D || ra);
        if (w && !wa) ov_m = 1'b1;
        if (r && m.size() == 0) un_m = 1'b1;
        if (ra) exp_q.push_back(m.pop_front());
        if (wa) m.push_back(d);
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        check_state(tag);
    endtask
    task automatic reset_cycle(input logic w, input logic r);
        rst = 1'b0;
        wr = w;
        rd = r;
        @(posedge clk);
        #1;
        m.delete();
        ov_m = 1'b0;
        un_m = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_vld", 32'(dout_vld), 32'd0);
        rst = 1'b1;
        wr = 1'b0;
        rd = 1'b0;
    endtask
    initial begin
        rst = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        din = '0;
        reset_cycle(1'b0, 1'b0);
        reset_cycle(1'bx, 1'bx);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'hA1 + 8'(i), "fill_a");
        chk("full_after_8", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, "drain_a");
        chk("empty_after_drain", 32'(empty), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i), "fill_c");
        step(1'b1, 1'b0, 8'hFF, "wr_full_drop");
        step(1'b0, 1'b0, 8'h00, "idle_after_drop");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hB0 + 8'(i), "full_wr_rd");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, "drain_b");
        step(1'b1, 1'b1, 8'h5C, "empty_wr_rd");
        chk("empty_wr_rd_vld", 32'(dout_vld), 32'd0);
        step(1'b0, 1'b1, 8'h00, "read_5c");
        step(1'b0, 1'b1, 8'h00, "rd_empty_drop");
        chk("rd_empty_vld", 32'(dout_vld), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hE0 + 8'(i), "fill_e");
        reset_cycle(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, i >= 3, 8'h60 + 8'(i), "wrap");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "wrap_drain");
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
